// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter: W-stage writeback has priority, long-latency results
// queue in a small FIFO, and a pending-destination scoreboard drives the decode stall.
module rf_wb_arbiter #(
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        clr_n,
  input  logic        wb_we,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  output logic        wb_hold,
  input  logic        lu_issue,
  input  logic [4:0]  lu_issue_rd,
  input  logic        lu_valid,
  input  logic [4:0]  lu_rd,
  input  logic [31:0] lu_data,
  output logic        lu_ready,
  input  logic [4:0]  rs1_d,
  input  logic [4:0]  rs2_d,
  input  logic [4:0]  rd_d,
  output logic        stall_d,
  output logic        rf_we,
  output logic [4:0]  rf_a3,
  output logic [31:0] rf_wd,
  output logic [31:0] pending
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } entry_t;

  entry_t          mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic [SW-1:0]   starve_cnt;
  logic            armed;
  logic [31:0]     pending_q;

  logic            empty, full, w_req, pop, push;
  entry_t          head;
  logic [31:0]     set_mask, clr_mask;

  assign empty    = (count == '0);
  assign full     = (count == CW'(FIFO_DEPTH));
  // armed keeps lu_ready low throughout reset even though the FIFO is empty.
  assign lu_ready = armed & ~full;
  assign wb_hold  = (starve_cnt == SW'(STARVE_LIMIT)) & ~empty;
  assign w_req    = wb_we & (wb_rd != 5'd0);
  assign head     = mem[rd_ptr];
  // rd 0 results complete the handshake but never enter the FIFO.
  assign push     = lu_valid & lu_ready & (lu_rd != 5'd0);

  // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
  always_comb begin
    rf_we = 1'b0;
    rf_a3 = 5'd0;
    rf_wd = 32'd0;
    pop   = 1'b0;
    if (!empty && (wb_hold || !w_req)) begin
      rf_we = 1'b1;
      rf_a3 = head.rd;
      rf_wd = head.data;
      pop   = 1'b1;
    end else if (w_req) begin
      rf_we = 1'b1;
      rf_a3 = wb_rd;
      rf_wd = wb_data;
    end
  end

  always_comb begin
    set_mask = 32'd0;
    clr_mask = 32'd0;
    if (lu_issue && lu_issue_rd != 5'd0) set_mask[lu_issue_rd] = 1'b1;
    if (pop)                             clr_mask[head.rd]     = 1'b1;
  end

  assign pending = pending_q;
  assign stall_d = pending_q[rs1_d] | pending_q[rs2_d] | pending_q[rd_d];

  // NOTE: result storage has no reset; count and pointers alone decide what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{rd: lu_rd, data: lu_data};
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      starve_cnt <= '0;
      armed      <= 1'b0;
      pending_q  <= 32'd0;
    end else begin
      armed <= 1'b1;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      // Set wins over a same-cycle clear of the same register.
      pending_q <= ((pending_q & ~clr_mask) | set_mask) & ~32'd1;
      if (empty || pop)
        starve_cnt <= '0;
      else if (starve_cnt != SW'(STARVE_LIMIT))
        starve_cnt <= starve_cnt + SW'(1);
    end
  end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Randomised and directed bench for rf_wb_arbiter against a queue-based reference model.
module tb_rf_wb_arbiter;

  localparam int DEPTH  = 2;
  localparam int LIMIT  = 4;

  logic        clk = 1'b0;
  logic        clr_n;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_hold;
  logic        lu_issue;
  logic [4:0]  lu_issue_rd;
  logic        lu_valid;
  logic [4:0]  lu_rd;
  logic [31:0] lu_data;
  logic        lu_ready;
  logic [4:0]  rs1_d, rs2_d, rd_d;
  logic        stall_d;
  logic        rf_we;
  logic [4:0]  rf_a3;
  logic [31:0] rf_wd;
  logic [31:0] pending;

  rf_wb_arbiter #(.FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .clr_n(clr_n),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .wb_hold(wb_hold),
    .lu_issue(lu_issue), .lu_issue_rd(lu_issue_rd),
    .lu_valid(lu_valid), .lu_rd(lu_rd), .lu_data(lu_data), .lu_ready(lu_ready),
    .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d), .stall_d(stall_d),
    .rf_we(rf_we), .rf_a3(rf_a3), .rf_wd(rf_wd), .pending(pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  // Reference model: result queue, pending bitmap, age of the waiting head.
  ent_t        q[$];
  logic [31:0] m_pend;
  int          age;
  bit          armed;

  int checks = 0;
  int errors = 0;
  int holds_seen = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    wb_we = 0; wb_rd = 0; wb_data = 0;
    lu_issue = 0; lu_issue_rd = 0;
    lu_valid = 0; lu_rd = 0; lu_data = 0;
    rs1_d = 0; rs2_d = 0; rd_d = 0;
  endtask

  // Called at a falling edge with inputs already driven; returns at the next falling edge.
  task automatic step();
    logic        e_hold, e_we, e_pop, e_ready, e_stall, wreq, acc, was_empty;
    logic [4:0]  e_a3;
    logic [31:0] e_wd;
    #2;
    if (!clr_n) begin
      q.delete(); m_pend = '0; age = 0; armed = 0;
    end
    wreq   = wb_we && (wb_rd != 0);
    e_hold = (age >= LIMIT) && (q.size() > 0);
    e_we = 0; e_a3 = 0; e_wd = 0; e_pop = 0;
    if (q.size() > 0 && (e_hold || !wreq)) begin
      e_we = 1; e_a3 = q[0].rd; e_wd = q[0].data; e_pop = 1;
    end else if (wreq) begin
      e_we = 1; e_a3 = wb_rd; e_wd = wb_data;
    end
    e_ready = armed && (q.size() < DEPTH);
    e_stall = m_pend[rs1_d] | m_pend[rs2_d] | m_pend[rd_d];
    check("wb_hold",  32'(wb_hold),  32'(e_hold));
    check("rf_we",    32'(rf_we),    32'(e_we));
    check("rf_a3",    32'(rf_a3),    32'(e_a3));
    check("rf_wd",    rf_wd,         e_wd);
    check("lu_ready", 32'(lu_ready), 32'(e_ready));
    check("stall_d",  32'(stall_d),  32'(e_stall));
    check("pending",  pending,       m_pend);
    if (wb_hold) holds_seen++;
    @(posedge clk);
    if (clr_n) begin
      acc       = lu_valid && e_ready;
      was_empty = (q.size() == 0);
      if (e_pop) begin
        m_pend[q[0].rd] = 1'b0;
        void'(q.pop_front());
      end
      if (acc && lu_rd != 0) q.push_back('{lu_rd, lu_data});
      if (lu_issue && lu_issue_rd != 0) m_pend[lu_issue_rd] = 1'b1;
      if (e_pop || was_empty) age = 0;
      else if (age < LIMIT)   age++;
      armed = 1;
    end
    @(negedge clk);
  endtask

  task automatic push_lu(input logic [4:0] rd, input logic [31:0] data);
    lu_valid = 1; lu_rd = rd; lu_data = data;
    step();
    lu_valid = 0; lu_rd = 0; lu_data = 0;
  endtask

  initial begin
    int h0;
    int wb_pct;
    idle_inputs();
    clr_n = 0;
    @(negedge clk);
    step();
    step();
    clr_n = 1;
    step();
    step();

    // Idle port: result written the cycle after acceptance, pending[5] clears.
    lu_issue = 1; lu_issue_rd = 5; step(); idle_inputs();
    push_lu(5'd5, 32'hDEAD_BEEF);
    check("idle_a3", 32'(rf_a3), 32'd5);
    check("idle_wd", rf_wd, 32'hDEAD_BEEF);
    step();
    check("idle_pending5", 32'(pending[5]), 32'd0);

    // Priority: W wins, head kept until W goes idle.
    push_lu(5'd7, 32'h0000_0777);
    wb_we = 1; wb_rd = 3; wb_data = 32'h33; step();
    wb_we = 0; wb_rd = 0; step();
    step();

    // Starvation: W busy every cycle while rd 9 waits; exactly one forced drain.
    wb_we = 1; wb_rd = 3; wb_data = 32'h3333;
    h0 = holds_seen;
    push_lu(5'd9, 32'h9999_0009);
    for (int i = 0; i < 8; i++) step();
    check("hold_once", 32'(holds_seen - h0), 32'd1);
    idle_inputs();
    step();

    // Hazards: rd 12 pending stalls decode until written; rd 0 issue never stalls.
    lu_issue = 1; lu_issue_rd = 12; rs1_d = 12; step();
    lu_issue = 0; step(); step();
    push_lu(5'd12, 32'h1212);
    step();
    lu_issue = 1; lu_issue_rd = 0; rs1_d = 0; rd_d = 0; step();
    idle_inputs(); step();

    // Full FIFO with a simultaneous offer: refused, pop proceeds, accepted next cycle.
    wb_we = 1; wb_rd = 1; wb_data = 32'h1;
    push_lu(5'd1, 32'hA1);
    push_lu(5'd2, 32'hA2);
    wb_we = 0; wb_rd = 0;
    lu_valid = 1; lu_rd = 4; lu_data = 32'hA4;
    step();
    step();
    idle_inputs();
    step(); step(); step();

    // Reset mid-stream with two results buffered and destinations pending.
    wb_we = 1; wb_rd = 6; wb_data = 32'h6;
    lu_issue = 1; lu_issue_rd = 10; step();
    lu_issue_rd = 11; push_lu(5'd10, 32'hB0);
    lu_issue = 0; push_lu(5'd11, 32'hB1);
    clr_n = 0; step();
    check("rst_count_ready", 32'(lu_ready), 32'd0);
    step();
    clr_n = 1; idle_inputs(); step();
    step();

    // Random traffic in phases of varying W pressure, with occasional resets.
    for (int p = 0; p < 8; p++) begin
      wb_pct = (p % 4 == 0) ? 100 : (p % 4 == 1) ? 80 : (p % 4 == 2) ? 40 : 10;
      for (int i = 0; i < 80; i++) begin
        wb_we       = ($urandom_range(99) < wb_pct);
        wb_rd       = 5'($urandom_range(31));
        wb_data     = $urandom;
        lu_issue    = ($urandom_range(3) == 0);
        lu_issue_rd = 5'($urandom_range(15));
        lu_valid    = ($urandom_range(1) == 0);
        lu_rd       = 5'($urandom_range(15));
        lu_data     = $urandom;
        rs1_d       = 5'($urandom_range(15));
        rs2_d       = 5'($urandom_range(15));
        rd_d        = 5'($urandom_range(15));
        clr_n       = ($urandom_range(149) != 0);
        step();
        clr_n = 1;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
